// File: rtl/elbeth_arb_pkg.sv
// Shared types and constants for the elbeth two-port memory arbiter.
package elbeth_arb_pkg;

    localparam int ARB_DEFAULT_TIMEOUT = 15;
    localparam int ARB_ADDR_W          = 8;
    localparam int ARB_RW_W            = 4;
    localparam int ARB_DATA_W          = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_RW_W-1:0]   rw;
        logic [ARB_DATA_W-1:0] wdata;
    } arb_req_t;

    function automatic arb_req_t pack_req(
        input logic [ARB_ADDR_W-1:0] addr,
        input logic [ARB_RW_W-1:0]   rw,
        input logic [ARB_DATA_W-1:0] wdata
    );
        arb_req_t r;
        r.addr  = addr;
        r.rw    = rw;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/elbeth_arb_timeout_counter.sv
// Granted-cycle counter for the arbiter; flags the last cycle allowed before abort.
module elbeth_arb_timeout_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       reached
);

    logic [7:0] count;

    // count holds the number of granted cycles already completed, so the
    // limit-th granted cycle is the one where count == limit-1.
    assign reached = (count == (limit - 8'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable && !reached) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/elbeth_mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-port memory.
// Optional round-robin fairness on simultaneous requests: define ELBETH_ARB_RR_EN.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | waiting for i_en/d_en, picks and latches a winner
// ST_GRANT_I | instruction request on the memory bus
// ST_GRANT_D | data request on the memory bus
// ST_DONE    | one dead cycle after completion, requests ignored
module elbeth_mem_arbiter
    import elbeth_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = ARB_DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_en,
    input  logic [7:0]  i_addr,
    input  logic [3:0]  i_rw,
    input  logic [31:0] i_wdata,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    output logic        i_error,

    input  logic        d_en,
    input  logic [7:0]  d_addr,
    input  logic [3:0]  d_rw,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_error,

    output logic        mem_en,
    output logic [7:0]  mem_addr,
    output logic [3:0]  mem_rw,
    output logic [31:0] mem_out_data,
    input  logic [31:0] mem_in_data,
    input  logic        mem_ready,
    input  logic        mem_error
);

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    arb_state_t state;
    arb_req_t   lat;

    logic granted;
    logic grant_i;
    logic grant_d;
    logic tmo_hit;
    logic finish;
    logic fail;
    logic pick_d;
    logic any_req;

    assign grant_i = (state == ST_GRANT_I);
    assign grant_d = (state == ST_GRANT_D);
    assign granted = grant_i || grant_d;
    assign any_req = i_en || d_en;

    // Error outranks ready; the timeout only counts when memory said nothing.
    assign finish = granted && (mem_error || mem_ready || tmo_hit);
    assign fail   = granted && (mem_error || (!mem_ready && tmo_hit));

`ifdef ELBETH_ARB_RR_EN
    logic last_d;

    assign pick_d = d_en && !(i_en && last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d <= 1'b0;
        end else if ((state == ST_IDLE) && any_req) begin
            last_d <= pick_d;
        end
    end
`else
    assign pick_d = d_en;
`endif

    elbeth_arb_timeout_counter u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clear   (!granted),
        .enable  (granted),
        .limit   (TMO_LIMIT),
        .reached (tmo_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            lat    <= '0;
            mem_en <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        mem_en <= 1'b1;
                        if (pick_d) begin
                            state <= ST_GRANT_D;
                            lat   <= pack_req(d_addr, d_rw, d_wdata);
                        end else begin
                            state <= ST_GRANT_I;
                            lat   <= pack_req(i_addr, i_rw, i_wdata);
                        end
                    end
                end
                ST_GRANT_I, ST_GRANT_D: begin
                    if (finish) begin
                        state  <= ST_DONE;
                        mem_en <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    mem_en <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr     = lat.addr;
    assign mem_rw       = lat.rw;
    assign mem_out_data = lat.wdata;

    // Responses are steered combinationally so completion lands in the
    // same cycle the memory answers.
    assign i_ready = grant_i && finish;
    assign i_error = grant_i && fail;
    assign i_rdata = (grant_i && mem_ready) ? mem_in_data : 32'd0;

    assign d_ready = grant_d && finish;
    assign d_error = grant_d && fail;
    assign d_rdata = (grant_d && mem_ready) ? mem_in_data : 32'd0;

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// Self-checking bench for elbeth_mem_arbiter: transaction-level model plus directed scenarios.
module tb_elbeth_mem_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        i_en = 1'b0;
    logic [7:0]  i_addr = 8'd0;
    logic [3:0]  i_rw = 4'd0;
    logic [31:0] i_wdata = 32'd0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        i_error;

    logic        d_en = 1'b0;
    logic [7:0]  d_addr = 8'd0;
    logic [3:0]  d_rw = 4'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_error;

    logic        mem_en;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_rw;
    logic [31:0] mem_out_data;
    logic [31:0] mem_in_data = 32'd0;
    logic        mem_ready = 1'b0;
    logic        mem_error = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    // memory behaviour: 0 ready, 1 silent, 2 ready+error, 3 error only
    int mem_mode = 0;
    int mem_age  = 0;

    logic [7:0] grants[$];
    logic       prev_en = 1'b0;

    elbeth_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_en         (i_en),
        .i_addr       (i_addr),
        .i_rw         (i_rw),
        .i_wdata      (i_wdata),
        .i_rdata      (i_rdata),
        .i_ready      (i_ready),
        .i_error      (i_error),
        .d_en         (d_en),
        .d_addr       (d_addr),
        .d_rw         (d_rw),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_ready      (d_ready),
        .d_error      (d_error),
        .mem_en       (mem_en),
        .mem_addr     (mem_addr),
        .mem_rw       (mem_rw),
        .mem_out_data (mem_out_data),
        .mem_in_data  (mem_in_data),
        .mem_ready    (mem_ready),
        .mem_error    (mem_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        if (a == 8'h10) return 32'hDEADBEEF;
        return {a, 24'h5A5A5A};
    endfunction

    // Memory: answers one cycle after mem_en rises (second granted cycle).
    always @(posedge clk) begin
        #1;
        mem_age     = mem_en ? mem_age + 1 : 0;
        mem_ready   = mem_en && (mem_age > 1) && (mem_mode == 0 || mem_mode == 2);
        mem_error   = mem_en && (mem_age > 1) && (mem_mode == 2 || mem_mode == 3);
        mem_in_data = mem_word(mem_addr);
    end

    // Transaction model: who owns the bus, how long, and the dead cycle after.
    int          m_owner  = 0;   // 0 none, 1 instruction, 2 data
    int          m_age    = 0;   // granted cycles including the current one
    bit          m_cool   = 1'b0;
    bit          m_last_d = 1'b0;
    bit          take_d;
    logic [7:0]  m_addr   = 8'd0;
    logic [3:0]  m_rw     = 4'd0;
    logic [31:0] m_wdata  = 32'd0;

    function automatic int m_result();
        if (m_owner == 0) return 0;
        if (mem_error)    return 2;
        if (mem_ready)    return 1;
        if (m_age == TMO) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner = 0; m_age = 0; m_cool = 1'b0; m_last_d = 1'b0;
            m_addr = 8'd0; m_rw = 4'd0; m_wdata = 32'd0;
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else if (m_owner != 0) begin
            if (m_result() != 0) begin
                m_owner = 0;
                m_cool  = 1'b1;
            end else begin
                m_age++;
            end
        end else if (i_en || d_en) begin
            take_d = d_en;
`ifdef ELBETH_ARB_RR_EN
            if (i_en && d_en) take_d = !m_last_d;
            m_last_d = take_d;
`endif
            m_owner = take_d ? 2 : 1;
            m_age   = 1;
            m_addr  = take_d ? d_addr  : i_addr;
            m_rw    = take_d ? d_rw    : i_rw;
            m_wdata = take_d ? d_wdata : i_wdata;
        end
    end

    int res;
    bit own_i;
    bit own_d;

    always @(negedge clk) begin
        if (!rst && mem_en && !prev_en) grants.push_back(mem_addr);
        prev_en = mem_en;
        if (cmp_on) begin
            res   = rst ? 0 : m_result();
            own_i = !rst && (m_owner == 1);
            own_d = !rst && (m_owner == 2);
            check("mem_en",       mem_en,       (!rst && m_owner != 0));
            check("mem_addr",     mem_addr,     rst ? 8'd0  : m_addr);
            check("mem_rw",       mem_rw,       rst ? 4'd0  : m_rw);
            check("mem_out_data", mem_out_data, rst ? 32'd0 : m_wdata);
            check("i_ready",      i_ready,      own_i && res != 0);
            check("i_error",      i_error,      own_i && res == 2);
            check("i_rdata",      i_rdata,      (own_i && mem_ready) ? mem_in_data : 32'd0);
            check("d_ready",      d_ready,      own_d && res != 0);
            check("d_error",      d_error,      own_d && res == 2);
            check("d_rdata",      d_rdata,      (own_d && mem_ready) ? mem_in_data : 32'd0);
        end
    end

    int cnt;

    initial begin
        repeat (2) @(posedge clk);
        #3;
        check("rst_mem_en",   mem_en,   1'b0);
        check("rst_mem_addr", mem_addr, 8'd0);
        check("rst_i_ready",  i_ready,  1'b0);
        check("rst_d_error",  d_error,  1'b0);

        // single instruction read, zero-wait memory
        rst = 1'b0; cmp_on = 1'b1;
        i_en = 1'b1; i_addr = 8'h10; i_rw = 4'h2; i_wdata = 32'h11111111;
        step();
        check("t1_mem_en",   mem_en,   1'b1);
        check("t1_mem_addr", mem_addr, 8'h10);
        check("t1_i_ready0", i_ready,  1'b0);
        i_addr = 8'h77; i_wdata = 32'h99999999;
        step();
        check("t1_addr_held",  mem_addr,     8'h10);
        check("t1_wdata_held", mem_out_data, 32'h11111111);
        check("t1_i_ready",    i_ready,      1'b1);
        check("t1_i_rdata",    i_rdata,      32'hDEADBEEF);
        check("t1_d_ready",    d_ready,      1'b0);
        i_en = 1'b0;
        step();
        check("t1_done_mem_en", mem_en,  1'b0);
        check("t1_ready_pulse", i_ready, 1'b0);
        step();

        // simultaneous requests, each drops en once served, twice
        grants.delete();
        i_addr = 8'h30; i_rw = 4'h2; i_wdata = 32'h33333333;
        d_addr = 8'h20; d_rw = 4'h5; d_wdata = 32'h22222222;
        repeat (2) begin
            i_en = 1'b1; d_en = 1'b1;
            for (int k = 0; k < 40 && (i_en || d_en); k++) begin
                step();
                if (d_ready) d_en = 1'b0;
                if (i_ready) i_en = 1'b0;
            end
            check("t2_completed", {30'd0, i_en, d_en}, 32'd0);
            i_en = 1'b0; d_en = 1'b0;
            step(); step();
        end
        check("t2_ngrants", grants.size(), 4);
        check("t2_g0", grants[0], 8'h20);
        check("t2_g1", grants[1], 8'h30);
        check("t2_g2", grants[2], 8'h20);
        check("t2_g3", grants[3], 8'h30);

        // both held for four transactions
        grants.delete();
        i_en = 1'b1; d_en = 1'b1; cnt = 0;
        for (int k = 0; k < 80 && cnt < 4; k++) begin
            step();
            if (i_ready || d_ready) cnt++;
        end
        i_en = 1'b0; d_en = 1'b0;
        step(); step();
        check("t3_count", cnt, 4);
        check("t3_ngrants", grants.size(), 4);
        check("t3_g0", grants[0], 8'h20);
`ifdef ELBETH_ARB_RR_EN
        check("t3_g1", grants[1], 8'h30);
        check("t3_g2", grants[2], 8'h20);
        check("t3_g3", grants[3], 8'h30);
`else
        check("t3_g1", grants[1], 8'h20);
        check("t3_g2", grants[2], 8'h20);
        check("t3_g3", grants[3], 8'h20);
`endif

        // silent memory: timeout on the 4th granted cycle
        mem_mode = 1; d_en = 1'b1; d_addr = 8'h40;
        step();
        check("t4_g1_mem_en", mem_en,  1'b1);
        check("t4_g1_ready",  d_ready, 1'b0);
        step(); step();
        check("t4_g3_ready",  d_ready, 1'b0);
        check("t4_g3_error",  d_error, 1'b0);
        step();
        check("t4_g4_error",  d_error, 1'b1);
        check("t4_g4_ready",  d_ready, 1'b1);
        check("t4_g4_i_rdy",  i_ready, 1'b0);
        d_en = 1'b0;
        step();
        check("t4_after_mem_en", mem_en,  1'b0);
        check("t4_after_error",  d_error, 1'b0);
        step();

        // ready and error together, then error alone
        mem_mode = 2; i_en = 1'b1; i_addr = 8'h50;
        step();
        check("t5_g1_ready", i_ready, 1'b0);
        step();
        check("t5_ready", i_ready, 1'b1);
        check("t5_error", i_error, 1'b1);
        i_en = 1'b0;
        step();
        check("t5_pulse_ready", i_ready, 1'b0);
        check("t5_pulse_error", i_error, 1'b0);
        step();
        mem_mode = 3; d_en = 1'b1; d_addr = 8'h58;
        step(); step();
        check("t5_eo_error", d_error, 1'b1);
        check("t5_eo_ready", d_ready, 1'b1);
        check("t5_eo_rdata", d_rdata, 32'd0);
        d_en = 1'b0;
        step(); step();
        mem_mode = 0;

        // reset in the middle of a data grant
        d_en = 1'b1; d_addr = 8'h60;
        step(); step();
        check("t6_pre_ready", d_ready, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_rst_mem_en",   mem_en,   1'b0);
        check("t6_rst_d_ready",  d_ready,  1'b0);
        check("t6_rst_mem_addr", mem_addr, 8'd0);
        d_en = 1'b0; i_en = 1'b1; i_addr = 8'h70;
        step();
        check("t6_hold_mem_en", mem_en, 1'b0);
        rst = 1'b0;
        step();
        check("t6_post_mem_en",   mem_en,   1'b1);
        check("t6_post_mem_addr", mem_addr, 8'h70);
        step();
        check("t6_post_i_ready", i_ready, 1'b1);
        check("t6_post_i_rdata", i_rdata, 32'h705A5A5A);
        i_en = 1'b0;
        step(); step();

        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

endmodule
